// File: rtl/trigout_burst_sequencer_if.sv
// Host/pin-side bundle for trigout_burst_sequencer.
// TRIGOUT_OVERRUN_EN adds the sticky overrun flag.
interface trigout_burst_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic             pswr;
  logic [1:0]       mode;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] burst_count;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] width;
  logic             tdout;
  logic             busy;
  logic             done;
`ifdef TRIGOUT_OVERRUN_EN
  logic             overrun;

  modport master (
    output en, pswr, mode, start, stop, burst_count, delay, width,
    input  tdout, busy, done, overrun
  );
  modport slave (
    input  en, pswr, mode, start, stop, burst_count, delay, width,
    output tdout, busy, done, overrun
  );
`else
  modport master (
    output en, pswr, mode, start, stop, burst_count, delay, width,
    input  tdout, busy, done
  );
  modport slave (
    input  en, pswr, mode, start, stop, burst_count, delay, width,
    output tdout, busy, done
  );
`endif
endinterface

// File: rtl/trigout_burst_sequencer.sv
// Trigger-out sequencer: delayed, width-programmable pulses per period wrap in continuous,
// burst or single-shot mode. Define TRIGOUT_OVERRUN_EN for the sticky dropped-edge flag.
module trigout_burst_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input logic                      clk,
  input logic                      rst,
  trigout_burst_sequencer_if.slave bus
);

  localparam logic [1:0] ModeOff   = 2'd0;
  localparam logic [1:0] ModeCont  = 2'd1;
  localparam logic [1:0] ModeBurst = 2'd2;

  typedef enum logic [1:0] {StIdle, StWaitEdge, StDelay, StPulse} state_e;

  state_e           state_q, state_d;
  logic             prev_q;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_q, stop_d;
  logic             tdout_q, tdout_d;
  logic             done_q, done_d;
  logic             edge_det;
  logic             stop_seen;
  logic             last_pulse;
`ifdef TRIGOUT_OVERRUN_EN
  logic             overrun_q, overrun_d;
`endif

  assign edge_det = bus.pswr & ~prev_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    delay_d    = delay_q;
    width_d    = width_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    stop_d     = stop_q;
    tdout_d    = 1'b0;
    done_d     = 1'b0;
    stop_seen  = stop_q | bus.stop;
    last_pulse = 1'b0;
`ifdef TRIGOUT_OVERRUN_EN
    overrun_d  = overrun_q;
    if ((state_q == StDelay || state_q == StPulse) && edge_det) overrun_d = 1'b1;
`endif
    unique case (state_q)
      StIdle: begin
        stop_d = 1'b0;
        if (bus.start && bus.mode != ModeOff) begin
          mode_d  = bus.mode;
          delay_d = bus.delay;
          width_d = (bus.width == '0) ? CNT_W'(1) : bus.width;
          rem_d   = bus.burst_count;
`ifdef TRIGOUT_OVERRUN_EN
          overrun_d = 1'b0;
`endif
          // An empty burst completes immediately without arming.
          if (bus.mode == ModeBurst && bus.burst_count == '0) done_d = 1'b1;
          else state_d = StWaitEdge;
        end
      end
      StWaitEdge: begin
        if (bus.stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (edge_det) begin
          if (delay_q == '0) begin
            state_d = StPulse;
            cnt_d   = width_q;
            tdout_d = 1'b1;
          end else begin
            state_d = StDelay;
            cnt_d   = delay_q;
          end
        end
      end
      StDelay: begin
        stop_d = stop_seen;
        if (cnt_q == CNT_W'(1)) begin
          state_d = StPulse;
          cnt_d   = width_q;
          tdout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StPulse: begin
        stop_d = stop_seen;
        if (cnt_q == CNT_W'(1)) begin
          case (mode_q)
            ModeCont:  last_pulse = stop_seen;
            ModeBurst: begin
              rem_d      = rem_q - CNT_W'(1);
              last_pulse = stop_seen || (rem_q == CNT_W'(1));
            end
            default:   last_pulse = 1'b1;
          endcase
          if (last_pulse) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StWaitEdge;
          end
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          tdout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      state_q   <= StIdle;
      prev_q    <= 1'b0;
      mode_q    <= ModeOff;
      delay_q   <= '0;
      width_q   <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      stop_q    <= 1'b0;
      tdout_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef TRIGOUT_OVERRUN_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      prev_q    <= bus.pswr;
      mode_q    <= mode_d;
      delay_q   <= delay_d;
      width_q   <= width_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      stop_q    <= stop_d;
      tdout_q   <= tdout_d;
      done_q    <= done_d;
`ifdef TRIGOUT_OVERRUN_EN
      overrun_q <= overrun_d;
`endif
    end
  end

  assign bus.tdout = tdout_q;
  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = done_q;
`ifdef TRIGOUT_OVERRUN_EN
  assign bus.overrun = overrun_q;
`endif

endmodule

// File: tb/tb_trigout_burst_sequencer.sv
// Bench for trigout_burst_sequencer: vector table, corner-case sequences and random stimulus
// checked against an event-time reference model.
module tb_trigout_burst_sequencer;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  trigout_burst_sequencer_if #(.CNT_W(16)) bus ();

  trigout_burst_sequencer #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pulse windows tracked as absolute sample times.
  longint m_t;
  bit     m_prev, m_active, m_wait, m_stop, m_over, m_done, m_tdout;
  int     m_mode, m_d, m_w, m_left;
  longint m_rise, m_fall;

  task automatic model_step();
    bit e;
    bit last;
    e      = bus.pswr && !m_prev;
    m_done = 1'b0;
    if (rst || !bus.en) begin
      m_active = 0; m_wait = 0; m_prev = 0; m_over = 0; m_stop = 0;
    end else begin
      m_prev = bus.pswr;
      if (!m_active) begin
        m_stop = 0;
        if (bus.start && bus.mode != 2'd0) begin
          m_over = 0;
          m_mode = int'(bus.mode);
          m_d    = int'(bus.delay);
          m_w    = (bus.width == 16'd0) ? 1 : int'(bus.width);
          m_left = int'(bus.burst_count);
          if (m_mode == 2 && m_left == 0) m_done = 1;
          else begin m_active = 1; m_wait = 1; end
        end
      end else if (m_wait) begin
        if (bus.stop) begin m_active = 0; m_done = 1; end
        else if (e) begin
          m_wait = 0;
          m_rise = m_t + m_d;
          m_fall = m_t + m_d + m_w;
        end
      end else begin
        if (bus.stop) m_stop = 1;
        if (e) m_over = 1;
        if (m_t == m_fall) begin
          last = (m_mode == 3) || m_stop || (m_mode == 2 && m_left == 1);
          if (m_mode == 2) m_left--;
          if (last) begin m_active = 0; m_done = 1; end
          else m_wait = 1;
        end
      end
    end
    m_tdout = m_active && !m_wait && (m_t >= m_rise) && (m_t < m_fall);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", name, m_t, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    check("model_tdout", bus.tdout, m_tdout);
    check("model_busy", bus.busy, m_active);
    check("model_done", bus.done, m_done);
`ifdef TRIGOUT_OVERRUN_EN
    check("model_overrun", bus.overrun, m_over);
`endif
    m_t++;
  endtask

  task automatic quiet();
    rst = 0; bus.en = 1; bus.start = 0; bus.stop = 0; bus.pswr = 0;
  endtask

  task automatic do_reset();
    quiet(); rst = 1; step(); rst = 0;
  endtask

  typedef struct {
    logic rst, en, start, stop, pswr;
    logic [1:0] mode;
    logic [15:0] burst, delay, width;
    logic tdout, busy, done;
  } vec_t;

  function automatic vec_t mk(input logic r, en, st, sp, p, input logic [1:0] md,
                              input int b, d, w, input logic et, eb, ed);
    vec_t v;
    v.rst = r; v.en = en; v.start = st; v.stop = sp; v.pswr = p; v.mode = md;
    v.burst = 16'(b); v.delay = 16'(d); v.width = 16'(w);
    v.tdout = et; v.busy = eb; v.done = ed;
    return v;
  endfunction

  vec_t vt[17];
  int   npulse, rise, donej, hi;
  logic prevtd, donebusy;
  int   ov_first;

  initial begin
    n_total = 0; n_bad = 0; m_t = 0;
    m_prev = 0; m_active = 0; m_wait = 0; m_stop = 0; m_over = 0; m_done = 0; m_tdout = 0;
    m_mode = 0; m_d = 0; m_w = 1; m_left = 0; m_rise = 0; m_fall = 0;
    quiet(); bus.mode = 0; bus.burst_count = 0; bus.delay = 0; bus.width = 0;

    //        rst en st sp p  md b  d  w   td bz dn
    vt[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset state
    vt[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // mode OFF start ignored
    vt[2]  = mk(0, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 1);  // empty burst -> done
    vt[3]  = mk(0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 1, 1, 1, 0, 3, 0, 0, 0, 0, 1, 0);  // start beats stop, single w=0
    vt[5]  = mk(0, 1, 0, 0, 1, 3, 0, 0, 0, 1, 1, 0);  // edge -> pulse
    vt[6]  = mk(0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1);  // 1-cycle pulse, done
    vt[7]  = mk(0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    vt[8]  = mk(0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);  // edge after single: nothing
    vt[9]  = mk(0, 1, 1, 0, 1, 1, 0, 1, 2, 0, 1, 0);  // continuous d=1 w=2
    vt[10] = mk(0, 1, 0, 0, 0, 1, 0, 1, 2, 0, 1, 0);
    vt[11] = mk(0, 1, 0, 0, 1, 1, 0, 1, 2, 0, 1, 0);  // edge -> delay
    vt[12] = mk(0, 1, 0, 0, 1, 1, 0, 1, 2, 1, 1, 0);
    vt[13] = mk(0, 1, 0, 0, 1, 1, 0, 1, 2, 1, 1, 0);
    vt[14] = mk(0, 1, 0, 0, 1, 1, 0, 1, 2, 0, 1, 0);  // back to waiting, no done
    vt[15] = mk(0, 1, 0, 1, 1, 1, 0, 1, 2, 0, 0, 1);  // stop while waiting
    vt[16] = mk(0, 1, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      rst = vt[i].rst; bus.en = vt[i].en; bus.start = vt[i].start; bus.stop = vt[i].stop;
      bus.pswr = vt[i].pswr; bus.mode = vt[i].mode; bus.burst_count = vt[i].burst;
      bus.delay = vt[i].delay; bus.width = vt[i].width;
      step();
      check("vec_tdout", bus.tdout, vt[i].tdout);
      check("vec_busy", bus.busy, vt[i].busy);
      check("vec_done", bus.done, vt[i].done);
    end

    // Burst of 4, delay 5, width 2; width change after start must be ignored.
    do_reset();
    bus.mode = 2; bus.burst_count = 4; bus.delay = 5; bus.width = 2; bus.start = 1;
    step();
    bus.start = 0; bus.width = 7;
    npulse = 0;
    for (int e = 0; e < 6; e++) begin
      bus.pswr = 1; step(); bus.pswr = 0;
      rise = -1; donej = -1; hi = 0; donebusy = 1'b1;
      for (int j = 1; j < 12; j++) begin
        prevtd = bus.tdout;
        step();
        if (bus.tdout) hi++;
        if (bus.tdout && !prevtd) begin npulse++; if (rise < 0) rise = j; end
        if (bus.done) begin donej = j; donebusy = bus.busy; end
      end
      if (e < 4) begin
        check("burst_rise", rise, 5);
        check("burst_width", hi, 2);
      end else check("burst_extra", rise, -1);
      if (e < 3) check("burst_early_done", donej, -1);
      if (e == 3) begin
        check("burst_done_at", donej, 7);
        check("burst_busy_done", donebusy, 0);
      end
    end
    check("burst_pulses", npulse, 4);

    // EN dropped mid-pulse, then clean restart.
    do_reset();
    bus.mode = 1; bus.width = 8; bus.delay = 0; bus.start = 1; step(); bus.start = 0;
    bus.pswr = 1; step(); bus.pswr = 0; step(); step();
    check("en_pre_tdout", bus.tdout, 1);
    bus.en = 0; step();
    check("en_abort_tdout", bus.tdout, 0);
    check("en_abort_busy", bus.busy, 0);
    check("en_abort_done", bus.done, 0);
    bus.en = 1; step();
    check("en_idle_done", bus.done, 0);
    bus.mode = 3; bus.width = 2; bus.start = 1; step(); bus.start = 0;
    check("restart_busy", bus.busy, 1);
    bus.pswr = 1; step(); bus.pswr = 0;
    check("restart_tdout", bus.tdout, 1);
    step(); step();
    check("restart_done", bus.done, 1);

    // Overrun: edge period 4, width 6 -> every other edge pulsed.
    do_reset();
    bus.mode = 1; bus.width = 6; bus.delay = 0; bus.start = 1; step(); bus.start = 0;
    npulse = 0; ov_first = -1;
    for (int i = 0; i < 20; i++) begin
      bus.pswr = (i % 4 == 0);
      prevtd = bus.tdout;
      step();
      if (bus.tdout && !prevtd) npulse++;
`ifdef TRIGOUT_OVERRUN_EN
      if (bus.overrun && ov_first < 0) ov_first = i;
`endif
    end
    bus.pswr = 0;
    check("overrun_pulses", npulse, 3);
    bus.stop = 1; step(); bus.stop = 0;
    repeat (4) step();
    check("overrun_stopped", bus.busy, 0);
`ifdef TRIGOUT_OVERRUN_EN
    check("overrun_first", ov_first, 4);
    check("overrun_sticky", bus.overrun, 1);
    bus.start = 1; step(); bus.start = 0;
    check("overrun_clear", bus.overrun, 0);
`endif

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      bus.en    = ($urandom_range(0, 199) != 0);
      bus.start = ($urandom_range(0, 11) == 0);
      bus.stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) bus.pswr = ~bus.pswr;
      bus.mode        = 2'($urandom_range(0, 3));
      bus.burst_count = 16'($urandom_range(0, 3));
      bus.delay       = 16'($urandom_range(0, 3));
      bus.width       = 16'($urandom_range(0, 3));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
